motor_pos_ctrl: RTL and testbench

Sequencer for one wheel's hall-sensor position counter (pos1/pos2 pair with clear, subtract and distance inputs). It opens fixed-length speed windows on pos1, latches each window's edge count as a speed sample, and executes distance moves on pos2 through a valid/ready command handshake. It also arbitrates the counter's single control path so that clear and subtract never collide. One instance sits between each counter instance and the motion-control logic.

---
 rtl/motor_ctrl_pkg.sv | 28 ++
 rtl/speed_window.sv | 82 ++++++++
 rtl/motor_pos_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_motor_pos_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_ctrl_pkg
//  Description : Shared types and constants for the wheel position sequencer.
//                Holds the move FSM state encoding, the position counter
//                width and the bit positions of the counter's clear vector.
//  Revision    : 1.0  initial release
// ============================================================================
package motor_ctrl_pkg;

    // Width of the pos1/pos2 counts and of move distances
    localparam int POS_W    = 16;

    // Bit positions inside the 2-bit clear vector sent to the counter
    localparam int CLR_POS1 = 0;
    localparam int CLR_POS2 = 1;

    // Move sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_RUN    = 3'd2,
        ST_SUB    = 3'd3,
        ST_SETTLE = 3'd4
    } move_state_e;

endpackage : motor_ctrl_pkg
`default_nettype wire

// File: rtl/speed_window.sv
`default_nettype none
// ============================================================================
//  Module      : speed_window
//  Description : Free-running speed window timer. At the end of every window
//                it requests a pos1 clear, yields to a concurrent subtract by
//                deferring the clear one cycle, and captures the final pos1
//                count as a speed sample while the clear is applied.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                subtract_now      - subtract will be driven next cycle
//                pos1              - speed count from the position counter
//                clear_pos1        - registered clear request for pos1
//                speed/speed_valid - captured window count and update pulse
//  Revision    : 1.0  initial release
// ============================================================================
module speed_window
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             subtract_now,
    input  logic [POS_W-1:0] pos1,
    output logic             clear_pos1,
    output logic [POS_W-1:0] speed,
    output logic             speed_valid
);

    localparam int unsigned        c_WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW_CYCLES - 1);

    logic [c_WIN_W-1:0] r_win_cnt_q;
    logic [c_WIN_W-1:0] w_win_cnt_d;
    logic               r_defer_q;
    logic               w_defer_d;
    logic               r_clear_q;
    logic               w_clear_d;
    logic [POS_W-1:0]   r_speed_q;
    logic [POS_W-1:0]   w_speed_d;
    logic               r_speed_valid_q;
    logic               w_speed_valid_d;
    logic               w_tc;
    logic               w_clr_req;

    always_comb begin
        w_tc        = (r_win_cnt_q == c_WIN_LAST);
        w_win_cnt_d = w_tc ? '0 : r_win_cnt_q + 1'b1;

        // The timer keeps its phase when a clear is deferred; only the clear
        // itself slips, so one window grows by a cycle and the next shrinks.
        w_clr_req   = w_tc | r_defer_q;
        w_clear_d   = w_clr_req & ~subtract_now;
        w_defer_d   = w_clr_req &  subtract_now;

        // pos1 still holds the full window count during the clear cycle; the
        // counter zeroes it on the same edge that captures it here.
        w_speed_d       = r_clear_q ? pos1 : r_speed_q;
        w_speed_valid_d = r_clear_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt_q     <= '0;
            r_defer_q       <= 1'b0;
            r_clear_q       <= 1'b0;
            r_speed_q       <= '0;
            r_speed_valid_q <= 1'b0;
        end else begin
            r_win_cnt_q     <= w_win_cnt_d;
            r_defer_q       <= w_defer_d;
            r_clear_q       <= w_clear_d;
            r_speed_q       <= w_speed_d;
            r_speed_valid_q <= w_speed_valid_d;
        end
    end

    assign clear_pos1  = r_clear_q;
    assign speed       = r_speed_q;
    assign speed_valid = r_speed_valid_q;

endmodule : speed_window
`default_nettype wire

// File: rtl/motor_pos_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pos_ctrl
//  Description : Sequencer for one wheel's hall-sensor position counter.
//                Runs fixed-length speed windows on pos1 and executes
//                distance moves on pos2 through a valid/ready command, while
//                keeping clear[0] and subtract from ever asserting together.
//  Ports       : clk, reset               - clock, sync active-high reset
//                pos1, pos2               - counts from the position counter
//                clear, subtract, distance - control path to the counter
//                cmd_valid, cmd_dist, cmd_ready - move command handshake
//                abort                    - cancel the active move
//                motor_en, done, stall    - move status
//                speed, speed_valid       - latest window speed sample
//  Config      : MOTOR_POS_CTRL_STALL_EN enables the stall watchdog in RUN;
//                without it stall is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_pos_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1000000,
    parameter int unsigned STALL_CYCLES  = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] pos1,
    input  logic [POS_W-1:0] pos2,
    output logic [1:0]       clear,
    output logic             subtract,
    output logic [POS_W-1:0] distance,
    input  logic             cmd_valid,
    input  logic [POS_W-1:0] cmd_dist,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             motor_en,
    output logic             done,
    output logic             stall,
    output logic [POS_W-1:0] speed,
    output logic             speed_valid
);

    move_state_e      r_state_q;
    move_state_e      w_state_d;
    logic [POS_W-1:0] r_target_q;
    logic [POS_W-1:0] w_target_d;
    logic             r_synced_q;
    logic             w_synced_d;
    logic             r_clear_pos2_q;
    logic             w_clear_pos2_d;
    logic             r_subtract_q;
    logic             w_subtract_d;
    logic             r_motor_en_q;
    logic             w_motor_en_d;
    logic             r_done_q;
    logic             w_done_d;
    logic             r_stall_q;
    logic             w_stall_d;
    logic             r_cmd_ready_q;
    logic             w_cmd_ready_d;
    logic             w_abort_path;
    logic             w_stall_hit;
    logic             w_clear_pos1;

`ifdef MOTOR_POS_CTRL_STALL_EN
    localparam int unsigned          c_STALL_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_CYCLES - 1);

    logic [c_STALL_W-1:0] r_stall_cnt_q;
    logic [c_STALL_W-1:0] w_stall_cnt_d;
    logic [POS_W-1:0]     r_pos2_prev_q;
    logic                 w_pos2_same;

    // Counts consecutive RUN cycles with no pos2 movement; any change or
    // leaving RUN restarts it.
    always_comb begin
        w_pos2_same   = (pos2 == r_pos2_prev_q);
        w_stall_cnt_d = '0;
        w_stall_hit   = 1'b0;
        if ((r_state_q == ST_RUN) && w_pos2_same) begin
            w_stall_hit   = (r_stall_cnt_q == c_STALL_LAST);
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt_q <= '0;
            r_pos2_prev_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
            r_pos2_prev_q <= pos2;
        end
    end
`else
    assign w_stall_hit = 1'b0;
`endif

    // Move sequencer; every output is registered from the next state so the
    // counter sees clean, glitch-free controls.
    always_comb begin
        w_state_d    = r_state_q;
        w_target_d   = r_target_q;
        w_synced_d   = r_synced_q;
        w_abort_path = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                // cmd_ready is registered, so the handshake is only honoured
                // once the port actually shows ready.
                if (cmd_valid && r_cmd_ready_q) begin
                    w_target_d = cmd_dist;
                    w_state_d  = r_synced_q ? ST_RUN : ST_CLR;
                end
            end
            ST_CLR: begin
                if (abort) begin
                    w_abort_path = 1'b1;
                end else begin
                    w_synced_d = 1'b1;
                    w_state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || w_stall_hit) begin
                    w_abort_path = 1'b1;
                end else if (pos2 >= r_target_q) begin
                    w_state_d = ST_SUB;
                end
            end
            ST_SUB:    w_state_d = ST_SETTLE;
            ST_SETTLE: w_state_d = ST_IDLE;
            default:   w_state_d = ST_IDLE;
        endcase

        // A cancelled move leaves pos2 at an unknown partial count, so it is
        // zeroed and the next move must start from a fresh clear.
        if (w_abort_path) begin
            w_state_d  = ST_IDLE;
            w_synced_d = 1'b0;
        end

        w_clear_pos2_d = (w_state_d == ST_CLR) | w_abort_path;
        w_motor_en_d   = (w_state_d == ST_RUN);
        w_subtract_d   = (w_state_d == ST_SUB);
        w_done_d       = (w_state_d == ST_SETTLE);
        // Ready is held off during the abort clear cycle.
        w_cmd_ready_d  = (w_state_d == ST_IDLE) & ~w_abort_path;
        w_stall_d      = w_stall_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_target_q     <= '0;
            r_synced_q     <= 1'b0;
            r_clear_pos2_q <= 1'b0;
            r_subtract_q   <= 1'b0;
            r_motor_en_q   <= 1'b0;
            r_done_q       <= 1'b0;
            r_stall_q      <= 1'b0;
            r_cmd_ready_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_target_q     <= w_target_d;
            r_synced_q     <= w_synced_d;
            r_clear_pos2_q <= w_clear_pos2_d;
            r_subtract_q   <= w_subtract_d;
            r_motor_en_q   <= w_motor_en_d;
            r_done_q       <= w_done_d;
            r_stall_q      <= w_stall_d;
            r_cmd_ready_q  <= w_cmd_ready_d;
        end
    end

    // The window timer is told about next cycle's subtract so it can push its
    // pos1 clear back by one cycle instead of colliding on the counter.
    speed_window #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_speed_window (
        .clk          (clk),
        .reset        (reset),
        .subtract_now (w_subtract_d),
        .pos1         (pos1),
        .clear_pos1   (w_clear_pos1),
        .speed        (speed),
        .speed_valid  (speed_valid)
    );

    assign clear[CLR_POS1] = w_clear_pos1;
    assign clear[CLR_POS2] = r_clear_pos2_q;
    assign subtract        = r_subtract_q;
    assign distance        = r_target_q;
    assign cmd_ready       = r_cmd_ready_q;
    assign motor_en        = r_motor_en_q;
    assign done            = r_done_q;
    assign stall           = r_stall_q;

endmodule : motor_pos_ctrl
`default_nettype wire

// File: tb/tb_motor_pos_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_pos_ctrl
//  Description : Directed self-checking bench for motor_pos_ctrl with a
//                behavioural position counter as the load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_motor_pos_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pos1;
    logic [15:0] pos2;
    logic [1:0]  clear;
    logic        subtract;
    logic [15:0] distance;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_dist = '0;
    logic        cmd_ready;
    logic        abort = 1'b0;
    logic        motor_en;
    logic        done;
    logic        stall;
    logic [15:0] speed;
    logic        speed_valid;
    logic        sensor = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int n_both = 0;
    int n_done = 0;
    int n_clr1 = 0;
    int n_sub  = 0;
    logic [15:0] last_dist = '0;

    always #5 clk = ~clk;

    motor_pos_ctrl #(
        .WINDOW_CYCLES (20),
        .STALL_CYCLES  (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pos1        (pos1),
        .pos2        (pos2),
        .clear       (clear),
        .subtract    (subtract),
        .distance    (distance),
        .cmd_valid   (cmd_valid),
        .cmd_dist    (cmd_dist),
        .cmd_ready   (cmd_ready),
        .abort       (abort),
        .motor_en    (motor_en),
        .done        (done),
        .stall       (stall),
        .speed       (speed),
        .speed_valid (speed_valid)
    );

    // Position counter load: counts sensor edges, honours clear and subtract
    always_ff @(posedge clk) begin
        if (reset) begin
            pos1 <= '0;
            pos2 <= '0;
        end else begin
            pos1 <= clear[0] ? 16'd0 : pos1 + {15'd0, sensor};
            if (clear[1])
                pos2 <= 16'd0;
            else if (subtract)
                pos2 <= pos2 - distance + {15'd0, sensor};
            else
                pos2 <= pos2 + {15'd0, sensor};
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (clear[0] && subtract) n_both = n_both + 1;
            if (done)                 n_done = n_done + 1;
            if (clear[1])             n_clr1 = n_clr1 + 1;
            if (subtract) begin
                n_sub     = n_sub + 1;
                last_dist = distance;
            end
        end
    end

    task automatic pulse();
        @(negedge clk) sensor = 1'b1;
        @(negedge clk) sensor = 1'b0;
    endtask

    task automatic wait_ready(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_clear0(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (clear[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (clear !== 2'b00) begin n_fail++; $display("FAIL reset_clear: got %0d expected 0", clear); end
        n_checks++; if (subtract !== 1'b0) begin n_fail++; $display("FAIL reset_subtract: got %0d expected 0", subtract); end
        n_checks++; if (distance !== 16'd0) begin n_fail++; $display("FAIL reset_distance: got %0d expected 0", distance); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %0d expected 0", cmd_ready); end
        n_checks++; if ({motor_en, done, stall, speed_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b expected 0000", {motor_en, done, stall, speed_valid}); end
        n_checks++; if (speed !== 16'd0) begin n_fail++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %0d expected 1", cmd_ready); end
    endtask

    task automatic test_speed();
        bit ok;
        wait_clear0(40, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL speed_first_clear0: got timeout expected clear[0]"); end
        for (int k = 0; k < 8; k++) pulse();
        repeat (4) @(negedge clk);
        n_checks++; if (clear[0] !== 1'b1) begin n_fail++; $display("FAIL speed_clear0_period: got %0d expected 1", clear[0]); end
        n_checks++; if (speed_valid !== 1'b0) begin n_fail++; $display("FAIL speed_valid_early: got %0d expected 0", speed_valid); end
        @(negedge clk);
        n_checks++; if (speed_valid !== 1'b1) begin n_fail++; $display("FAIL speed_valid_pulse: got %0d expected 1", speed_valid); end
        n_checks++; if (speed !== 16'd8) begin n_fail++; $display("FAIL speed_value: got %0d expected 8", speed); end
        n_checks++; if (clear[0] !== 1'b0) begin n_fail++; $display("FAIL speed_clear0_one_cycle: got %0d expected 0", clear[0]); end
    endtask

    task automatic test_first_move();
        bit ok;
        int clr0, don0, sub0;
        wait_ready(20, ok);
        clr0 = n_clr1; don0 = n_done; sub0 = n_sub;
        cmd_valid = 1'b1; cmd_dist = 16'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (clear[1] !== 1'b1) begin n_fail++; $display("FAIL move1_clr_state: got clear1=%0d expected 1", clear[1]); end
        n_checks++; if (motor_en !== 1'b0) begin n_fail++; $display("FAIL move1_motor_in_clr: got %0d expected 0", motor_en); end
        @(negedge clk);
        n_checks++; if (motor_en !== 1'b1) begin n_fail++; $display("FAIL move1_motor_run: got %0d expected 1", motor_en); end
        for (int k = 0; k < 7; k++) pulse();
        wait_ready(20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL move1_ready_timeout: got timeout expected ready"); end
        n_checks++; if (n_clr1 - clr0 !== 1) begin n_fail++; $display("FAIL move1_clear1_count: got %0d expected 1", n_clr1 - clr0); end
        n_checks++; if (n_sub - sub0 !== 1 || last_dist !== 16'd5) begin n_fail++; $display("FAIL move1_subtract: got count=%0d dist=%0d expected count=1 dist=5", n_sub - sub0, last_dist); end
        n_checks++; if (n_done - don0 !== 1) begin n_fail++; $display("FAIL move1_done_count: got %0d expected 1", n_done - don0); end
        n_checks++; if (pos2 !== 16'd2) begin n_fail++; $display("FAIL move1_pos2: got %0d expected 2", pos2); end
    endtask

    task automatic test_second_move();
        bit ok;
        int clr0, don0;
        wait_ready(20, ok);
        clr0 = n_clr1; don0 = n_done;
        cmd_valid = 1'b1; cmd_dist = 16'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (motor_en !== 1'b1 || clear[1] !== 1'b0) begin n_fail++; $display("FAIL move2_direct_run: got motor_en=%0d clear1=%0d expected 1/0", motor_en, clear[1]); end
        pulse();
        wait_ready(20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL move2_ready_timeout: got timeout expected ready"); end
        n_checks++; if (n_clr1 - clr0 !== 0) begin n_fail++; $display("FAIL move2_no_clear1: got %0d expected 0", n_clr1 - clr0); end
        n_checks++; if (n_done - don0 !== 1 || last_dist !== 16'd3) begin n_fail++; $display("FAIL move2_done: got done=%0d dist=%0d expected 1/3", n_done - don0, last_dist); end
        n_checks++; if (pos2 !== 16'd0) begin n_fail++; $display("FAIL move2_pos2: got %0d expected 0", pos2); end
    endtask

    task automatic test_collision();
        bit ok;
        wait_ready(20, ok);
        wait_clear0(40, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll_align: got timeout expected clear[0]"); end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dist = 16'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (motor_en !== 1'b1) begin n_fail++; $display("FAIL coll_run: got %0d expected 1", motor_en); end
        repeat (16) @(negedge clk);
        sensor = 1'b1;
        @(negedge clk);
        sensor = 1'b0;
        @(negedge clk);
        n_checks++; if (subtract !== 1'b1 || clear[0] !== 1'b0) begin n_fail++; $display("FAIL coll_sub_first: got sub=%0d clr0=%0d expected 1/0", subtract, clear[0]); end
        @(negedge clk);
        n_checks++; if (clear[0] !== 1'b1 || subtract !== 1'b0) begin n_fail++; $display("FAIL coll_clr0_deferred: got clr0=%0d sub=%0d expected 1/0", clear[0], subtract); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL coll_done: got %0d expected 1", done); end
        @(negedge clk);
        n_checks++; if (speed_valid !== 1'b1 || speed !== 16'd1) begin n_fail++; $display("FAIL coll_speed: got valid=%0d speed=%0d expected 1/1", speed_valid, speed); end
        repeat (18) @(negedge clk);
        n_checks++; if (clear[0] !== 1'b1) begin n_fail++; $display("FAIL coll_no_rephase: got %0d expected 1", clear[0]); end
        n_checks++; if (pos2 !== 16'd0) begin n_fail++; $display("FAIL coll_pos2: got %0d expected 0", pos2); end
    endtask

    task automatic test_abort();
        bit ok;
        int don0;
        wait_ready(20, ok);
        cmd_valid = 1'b1; cmd_dist = 16'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) pulse();
        don0 = n_done;
        n_checks++; if (pos2 !== 16'd3) begin n_fail++; $display("FAIL abort_pre_pos2: got %0d expected 3", pos2); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (motor_en !== 1'b0 || clear[1] !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort_response: got motor_en=%0d clear1=%0d ready=%0d expected 0/1/0", motor_en, clear[1], cmd_ready); end
        @(negedge clk);
        n_checks++; if (clear[1] !== 1'b0 || cmd_ready !== 1'b1 || pos2 !== 16'd0) begin n_fail++; $display("FAIL abort_after: got clear1=%0d ready=%0d pos2=%0d expected 0/1/0", clear[1], cmd_ready, pos2); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (clear[1] !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_noeffect: got clear1=%0d ready=%0d expected 0/1", clear[1], cmd_ready); end
        n_checks++; if (n_done - don0 !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", n_done - don0); end
        cmd_valid = 1'b1; cmd_dist = 16'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (clear[1] !== 1'b1 || motor_en !== 1'b0) begin n_fail++; $display("FAIL abort_next_clr: got clear1=%0d motor_en=%0d expected 1/0", clear[1], motor_en); end
        @(negedge clk);
        for (int k = 0; k < 3; k++) pulse();
        wait_ready(20, ok);
        n_checks++; if (n_done - don0 !== 1 || pos2 !== 16'd1) begin n_fail++; $display("FAIL abort_next_move: got done=%0d pos2=%0d expected 1/1", n_done - don0, pos2); end
    endtask

    task automatic test_cmd_zero();
        bit ok;
        logic [15:0] p;
        wait_ready(20, ok);
        p = pos2;
        cmd_valid = 1'b1; cmd_dist = 16'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (motor_en !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_run: got motor_en=%0d done=%0d expected 1/0", motor_en, done); end
        @(negedge clk);
        n_checks++; if (subtract !== 1'b1 || distance !== 16'd0) begin n_fail++; $display("FAIL zero_sub: got sub=%0d dist=%0d expected 1/0", subtract, distance); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_latency: got %0d expected 1", done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || pos2 !== p) begin n_fail++; $display("FAIL zero_after: got done=%0d ready=%0d pos2=%0d expected 0/1/%0d", done, cmd_ready, pos2, p); end
    endtask

    task automatic test_stall();
        bit ok;
        int hit_at;
        int stall_seen;
        wait_ready(20, ok);
        cmd_valid = 1'b1; cmd_dist = 16'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef MOTOR_POS_CTRL_STALL_EN
        hit_at = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (stall) begin
                hit_at = k;
                break;
            end
        end
        n_checks++; if (hit_at !== 50) begin n_fail++; $display("FAIL stall_timing: got cycle %0d expected 50", hit_at); end
        n_checks++; if (motor_en !== 1'b0 || clear[1] !== 1'b1) begin n_fail++; $display("FAIL stall_abort: got motor_en=%0d clear1=%0d expected 0/1", motor_en, clear[1]); end
        stall_seen = 0;
`else
        hit_at = 0;
        stall_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (stall) stall_seen++;
            if (!motor_en) hit_at++;
        end
        n_checks++; if (stall_seen !== 0) begin n_fail++; $display("FAIL nostall_stall: got %0d pulses expected 0", stall_seen); end
        n_checks++; if (hit_at !== 0 || motor_en !== 1'b1) begin n_fail++; $display("FAIL nostall_motor: got %0d low cycles expected 0", hit_at); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif
        wait_ready(20, ok);
        n_checks++; if (ok !== 1'b1 || stall_seen !== 0) begin n_fail++; $display("FAIL stall_recover: got ready=%0d expected 1", ok); end
    endtask

    initial begin
        test_reset();
        test_speed();
        test_first_move();
        test_second_move();
        test_collision();
        test_abort();
        test_cmd_zero();
        test_stall();
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL clear0_subtract_overlap: got %0d cycles expected 0", n_both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_motor_pos_ctrl
`default_nettype wire
